packet_sender: RTL and testbench
================================

# packet_sender

Packet transmitter for the sop/eop/val/data streaming interface consumed by the sorting pipeline. On a start command it waits until the downstream block deasserts busy, then emits one packet of a programmable length. Packet data come from an internal 16-bit LFSR. It serves as the upstream stimulus and traffic source for the sorter, both on the board and in system-level benches.

## Interface
Parameters:
- AWIDTH, 5, log2 of the maximum packet length; maximum is 2^AWIDTH words.
- DWIDTH, 8, data word width; legal range 1..16.

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- srst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  start command; sampled only in IDLE.
- len_i  in  AWIDTH+1  packet length in words; latched on accepted start.
- seed_i  in  16  LFSR seed; latched on accepted start.
- busy_i  in  1  downstream busy; a packet may begin only while it is low.
- data_o  out  DWIDTH  packet word.
- sop_o  out  1  first word of the packet.
- eop_o  out  1  last word of the packet.
- val_o  out  1  qualifies data_o, sop_o and eop_o.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse after the eop beat.

## Operation
- FSM states: IDLE, WAIT, SEND.
- IDLE -> WAIT on start_i=1 with len_i!=0.
  - Latches length, clamped to 2^AWIDTH if larger.
  - Latches seed; seed 0 is replaced by 16'hACE1.
  - Clears the beat counter (AWIDTH+1 bits).
  - start_i with len_i=0 is ignored; the FSM stays in IDLE.
- WAIT -> SEND when busy_i is sampled low; WAIT holds while busy_i=1.
- SEND: one beat per enabled cycle.
  - First beat: sop_o=1.
  - Beat with count == length-1: eop_o=1; next state IDLE; done_o=1 in the following cycle.
  - busy_i is ignored once in SEND, because downstream raises busy on sop.
- LFSR is Fibonacci, shift-left: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
  - data_o = s[DWIDTH-1:0] of the current state.
  - The state advances after each emitted beat.
  - The first beat carries the latched seed itself.
- Length 1: a single beat with sop_o=eop_o=val_o=1.
- start_i outside IDLE is ignored; there is no abort.
- sop_o, eop_o and data_o are meaningful only while val_o=1; sop_o and eop_o are 0 whenever val_o=0.
- srst_i in any state:
  - Next state is IDLE.
  - Packet is truncated; no eop is emitted.
  - Counter and LFSR are cleared.

## Timing
- All outputs are registered.
- Reset values: data_o=0, sop_o=0, eop_o=0, val_o=0, done_o=0, ready_o=1.
- Start accepted at edge N: ready_o=0 from N+1.
- busy_i low at edge N+1: sop beat visible in cycle N+2, giving a minimum start-to-sop latency of 2 cycles.
- In general, the sop beat follows the first edge at which busy_i is sampled low by exactly 1 cycle.
- Without gaps, a packet of L words occupies L consecutive val_o cycles.
- eop beat in cycle M:
  - done_o=1 and ready_o=1 in cycle M+1.
  - A new start is accepted at the end of cycle M+1 at the earliest.
- Reset asserted at edge K: all outputs hold their reset values from cycle K+1.

## Configuration
- PACKET_SENDER_GAPS_EN defined:
  - Exactly one idle cycle (val_o=0) follows every non-eop beat.
  - The val_o pattern is 1,0,1,0,…,1; the LFSR does not advance on idle cycles.
  - A packet of L words spans 2L-1 cycles.
- PACKET_SENDER_GAPS_EN undefined: beats are back-to-back, no gap logic is present, and a packet of L words spans L cycles.

## Test plan
- DWIDTH=8, seed 16'h0001, len 4, busy_i=0: data 01,02,04,08; sop with 01, eop with 08; sop 2 cycles after start; done_o one cycle after eop.
- len 1, seed 0: single beat with data E1 and sop=eop=val=1; ready_o returns high the next cycle.
- busy_i held high for 5 cycles after start: val_o stays 0 throughout; sop appears exactly 1 cycle after the first edge with busy_i low.
- len 0: no packet and ready_o stays 1. len 40 with AWIDTH=5: exactly 32 beats, eop on beat 32.
- srst_i asserted on the third beat of an 8-word packet: next cycle val_o=0, no eop, ready_o=1; a fresh start then produces a full packet starting from the seed.
- PACKET_SENDER_GAPS_EN defined, len 3, seed 16'h0001: val_o pattern 1,0,1,0,1 with data 01,02,04; done_o one cycle after the eop beat.

Source files
------------

// File: rtl/packet_sender.sv
// packet_sender: sop/eop/val/data packet source for the sorting pipeline.
// On an accepted start it waits for busy_i to drop, then emits one packet of
// the latched length, carrying words taken from a 16-bit Fibonacci LFSR.
// Optional feature: define PACKET_SENDER_GAPS_EN to insert one idle cycle
// after every non-eop beat; left undefined, beats are back-to-back.
module packet_sender #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    input  logic [15:0]       seed_i,
    input  logic              busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              ready_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    localparam logic [AWIDTH:0] MAX_LEN      = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE          = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [15:0]     SEED_DEFAULT = 16'hACE1;

    state_t              state_q, state_d;
    logic [AWIDTH:0]     len_q,   len_d;
    logic [AWIDTH:0]     cnt_q,   cnt_d;
    logic [15:0]         lfsr_q,  lfsr_d;
    logic [DWIDTH-1:0]   data_q,  data_d;
    logic                sop_q,   sop_d;
    logic                eop_q,   eop_d;
    logic                val_q,   val_d;
    logic                ready_q, ready_d;
    logic                done_q,  done_d;
    logic                emit;

    // Shift-left Fibonacci step: taps 16, 14, 13, 11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Next-state, beat generation and registered-output values.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        val_d   = 1'b0;
        done_d  = 1'b0;
        emit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    state_d = WAIT;
                    len_d   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                    lfsr_d  = (seed_i == 16'h0000) ? SEED_DEFAULT : seed_i;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // The first beat is registered on the same edge that sees busy low.
                if (!busy_i) begin
                    state_d = SEND;
                    emit    = 1'b1;
                end
            end
            SEND: begin
                // busy_i is deliberately ignored here: downstream raises it on sop.
                if (eop_q) begin
                    // Leaving SEND only after the eop beat has been shown keeps
                    // ready low during eop and places done in the cycle after it.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
`ifdef PACKET_SENDER_GAPS_EN
                    // A beat on the output now means this cycle is the gap.
                    emit = !val_q;
`else
                    emit = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            data_d = lfsr_q[DWIDTH-1:0];
            val_d  = 1'b1;
            sop_d  = (state_q == WAIT);
            eop_d  = (cnt_q == (len_q - ONE));
            cnt_d  = cnt_q + ONE;
            lfsr_d = lfsr_next(lfsr_q);
        end

        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge value regardless of statement order.
        if (srst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lfsr_q  <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            val_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            val_q   <= val_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign val_o   = val_q;
    assign ready_o = ready_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_packet_sender.sv
// Directed testbench for packet_sender (AWIDTH=5, DWIDTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_packet_sender;

    localparam int AW = 5;
    localparam int DW = 8;
`ifdef PACKET_SENDER_GAPS_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic [AW:0]   len;
    logic [15:0]   seed;
    logic          busy;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          val;
    logic          ready;
    logic          done;

    int checks   = 0;
    int failures = 0;

    // Captured packet: one entry per val beat, plus per-cycle val pattern.
    logic [DW-1:0] b_data[$];
    bit            b_sop[$];
    bit            b_eop[$];
    bit            b_ready[$];
    int            b_cyc[$];
    bit            c_val[$];
    int            done_at;
    bit            done_ready;
    bit            timed_out;

    packet_sender #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk_i   (clk),
        .srst_i  (srst),
        .start_i (start),
        .len_i   (len),
        .seed_i  (seed),
        .busy_i  (busy),
        .data_o  (data),
        .sop_o   (sop),
        .eop_o   (eop),
        .val_o   (val),
        .ready_o (ready),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // One-cycle start pulse; returns at the falling edge after acceptance.
    task automatic start_pkt(input logic [AW:0] l, input logic [15:0] s);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Record cycles until done_o or the budget runs out; cycle 1 is the next falling edge.
    task automatic capture(input int budget);
        int cyc;
        b_data.delete(); b_sop.delete(); b_eop.delete();
        b_ready.delete(); b_cyc.delete(); c_val.delete();
        done_at    = -1;
        done_ready = 1'b0;
        cyc        = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            c_val.push_back(val);
            if (val) begin
                b_data.push_back(data);
                b_sop.push_back(sop);
                b_eop.push_back(eop);
                b_ready.push_back(ready);
                b_cyc.push_back(cyc);
            end
            if (done) begin
                done_at    = cyc;
                done_ready = ready;
                break;
            end
        end
        timed_out = (done_at < 0);
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; busy = 1'b0; len = '0; seed = '0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 0", data); end
        checks++; if (sop !== 1'b0) begin failures++; $display("FAIL reset_sop: got %0b expected 0", sop); end
        checks++; if (eop !== 1'b0) begin failures++; $display("FAIL reset_eop: got %0b expected 0", eop); end
        checks++; if (val !== 1'b0) begin failures++; $display("FAIL reset_val: got %0b expected 0", val); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", ready); end
        srst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        start_pkt(4, 16'h0001);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_after_start: got %0b expected 0", ready); end
        capture(40);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (b_data.size() != 4) begin failures++; $display("FAIL basic_beats: got %0d expected 4", b_data.size()); end
        for (int i = 0; i < b_data.size() && i < 4; i++) begin
            checks++; if (b_data[i] !== exp_d[i]) begin failures++; $display("FAIL basic_data%0d: got %0h expected %0h", i, b_data[i], exp_d[i]); end
            checks++; if (b_sop[i] !== (i == 0)) begin failures++; $display("FAIL basic_sop%0d: got %0b expected %0b", i, b_sop[i], i == 0); end
            checks++; if (b_eop[i] !== (i == 3)) begin failures++; $display("FAIL basic_eop%0d: got %0b expected %0b", i, b_eop[i], i == 3); end
            checks++; if (b_cyc[i] != 1 + i * STRIDE) begin failures++; $display("FAIL basic_cycle%0d: got %0d expected %0d", i, b_cyc[i], 1 + i * STRIDE); end
        end
        if (b_ready.size() == 4) begin
            checks++; if (b_ready[3] !== 1'b0) begin failures++; $display("FAIL basic_ready_at_eop: got %0b expected 0", b_ready[3]); end
        end
        checks++; if (done_at != 2 + 3 * STRIDE) begin failures++; $display("FAIL basic_done_cycle: got %0d expected %0d", done_at, 2 + 3 * STRIDE); end
        checks++; if (done_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_at_done: got %0b expected 1", done_ready); end
    endtask

    task automatic test_len1();
        start_pkt(1, 16'h0000);
        capture(20);
        checks++; if (b_data.size() != 1) begin failures++; $display("FAIL len1_beats: got %0d expected 1", b_data.size()); end
        if (b_data.size() >= 1) begin
            checks++; if (b_data[0] !== 8'hE1) begin failures++; $display("FAIL len1_data: got %0h expected e1", b_data[0]); end
            checks++; if (b_sop[0] !== 1'b1 || b_eop[0] !== 1'b1) begin failures++; $display("FAIL len1_sop_eop: got %0b%0b expected 11", b_sop[0], b_eop[0]); end
        end
        checks++; if (done_at != 2) begin failures++; $display("FAIL len1_done_cycle: got %0d expected 2", done_at); end
        checks++; if (done_ready !== 1'b1) begin failures++; $display("FAIL len1_ready: got %0b expected 1", done_ready); end
    endtask

    task automatic test_busy();
        int bad;
        logic [7:0] exp_d[3] = '{8'h05, 8'h0A, 8'h14};
        busy = 1'b1;
        start_pkt(3, 16'h0005);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (val !== 1'b0 || ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL busy_hold: got %0d bad cycles expected 0", bad); end
        busy = 1'b0;
        capture(40);
        checks++; if (b_data.size() != 3) begin failures++; $display("FAIL busy_beats: got %0d expected 3", b_data.size()); end
        if (b_data.size() == 3) begin
            checks++; if (b_cyc[0] != 1 || b_sop[0] !== 1'b1) begin failures++; $display("FAIL busy_sop_latency: got cycle %0d sop %0b expected cycle 1 sop 1", b_cyc[0], b_sop[0]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (b_data[i] !== exp_d[i]) begin failures++; $display("FAIL busy_data%0d: got %0h expected %0h", i, b_data[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_len0();
        int bad;
        @(negedge clk);
        start = 1'b1; len = '0; seed = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (6) begin
            if (val !== 1'b0 || ready !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL len0_ignored: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_clamp();
        int eops;
        int mism;
        logic [15:0] s;
        start_pkt(6'd40, 16'h0001);
        capture(200);
        checks++; if (b_data.size() != 32) begin failures++; $display("FAIL clamp_beats: got %0d expected 32", b_data.size()); end
        eops = 0; mism = 0; s = 16'h0001;
        for (int i = 0; i < b_data.size(); i++) begin
            if (b_eop[i]) eops++;
            if (b_data[i] !== s[7:0]) mism++;
            s = model_next(s);
        end
        checks++; if (eops != 1) begin failures++; $display("FAIL clamp_eop_count: got %0d expected 1", eops); end
        if (b_data.size() == 32) begin
            checks++; if (b_eop[31] !== 1'b1) begin failures++; $display("FAIL clamp_eop_last: got %0b expected 1", b_eop[31]); end
        end
        checks++; if (mism != 0) begin failures++; $display("FAIL clamp_data: got %0d wrong words expected 0", mism); end
        checks++; if (done_at != 2 + 31 * STRIDE) begin failures++; $display("FAIL clamp_done_cycle: got %0d expected %0d", done_at, 2 + 31 * STRIDE); end
    endtask

    task automatic test_srst_mid();
        int n;
        int cyc;
        int bad;
        int mism;
        logic [15:0] s;
        start_pkt(8, 16'h1234);
        n = 0; cyc = 0;
        while (n < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (val) n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL srst_reach_beat3: got %0d beats expected 3", n); end
        checks++; if (eop !== 1'b0) begin failures++; $display("FAIL srst_beat3_eop: got %0b expected 0", eop); end
        srst = 1'b1;
        @(negedge clk);
        checks++; if (val !== 1'b0 || eop !== 1'b0 || sop !== 1'b0) begin failures++; $display("FAIL srst_outputs: got val %0b sop %0b eop %0b expected 000", val, sop, eop); end
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL srst_ready_done: got ready %0b done %0b expected 1 0", ready, done); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL srst_data: got %0h expected 0", data); end
        srst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (val !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL srst_truncated: got %0d active cycles expected 0", bad); end
        start_pkt(8, 16'h1234);
        capture(60);
        checks++; if (b_data.size() != 8) begin failures++; $display("FAIL srst_restart_beats: got %0d expected 8", b_data.size()); end
        mism = 0; s = 16'h1234;
        for (int i = 0; i < b_data.size(); i++) begin
            if (b_data[i] !== s[7:0]) mism++;
            if (b_sop[i] !== (i == 0) || b_eop[i] !== (i == 7)) mism++;
            s = model_next(s);
        end
        checks++; if (mism != 0) begin failures++; $display("FAIL srst_restart_packet: got %0d wrong beats expected 0", mism); end
    endtask

    task automatic test_gaps();
        int span;
        logic [7:0] exp_d[3] = '{8'h01, 8'h02, 8'h04};
        start_pkt(3, 16'h0001);
        capture(40);
        span = 1 + 2 * STRIDE;
        checks++; if (c_val.size() < span) begin failures++; $display("FAIL gaps_span: got %0d cycles expected at least %0d", c_val.size(), span); end
        for (int c = 0; c < span && c < c_val.size(); c++) begin
            checks++; if (c_val[c] !== ((c % STRIDE) == 0)) begin failures++; $display("FAIL gaps_val_cycle%0d: got %0b expected %0b", c + 1, c_val[c], (c % STRIDE) == 0); end
        end
        checks++; if (b_data.size() != 3) begin failures++; $display("FAIL gaps_beats: got %0d expected 3", b_data.size()); end
        for (int i = 0; i < b_data.size() && i < 3; i++) begin
            checks++; if (b_data[i] !== exp_d[i]) begin failures++; $display("FAIL gaps_data%0d: got %0h expected %0h", i, b_data[i], exp_d[i]); end
        end
        checks++; if (done_at != span + 1) begin failures++; $display("FAIL gaps_done_cycle: got %0d expected %0d", done_at, span + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len1();
        test_busy();
        test_len0();
        test_clamp();
        test_srst_mid();
        test_gaps();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
